// File: rtl/cpu_mem_arbiter_if.sv
// Bus bundle for cpu_mem_arbiter: CPU fetch channel, CPU data channel and shared memory port.
// The slave modport is the arbiter's view; master is the CPU and memory environment.
interface cpu_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   inst_addr;
    logic                inst_req_valid;
    logic                inst_req_ready;
    logic [DATA_W-1:0]   inst_rdata;
    logic                inst_rvalid;
    logic                inst_rready;

    logic [ADDR_W-1:0]   data_addr;
    logic                data_wen;
    logic [DATA_W-1:0]   data_wdata;
    logic [DATA_W/8-1:0] data_wstrb;
    logic                data_ren;
    logic                data_req_ready;
    logic [DATA_W-1:0]   data_rdata;
    logic                data_rvalid;
    logic                data_rready;

    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_wen;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_wstrb;
    logic                mem_ren;
    logic                mem_req_ready;
    logic [DATA_W-1:0]   mem_rdata;
    logic                mem_rvalid;
    logic                mem_rready;

    modport slave (
        input  inst_addr, inst_req_valid, inst_rready,
        input  data_addr, data_wen, data_wdata, data_wstrb, data_ren, data_rready,
        input  mem_req_ready, mem_rdata, mem_rvalid,
        output inst_req_ready, inst_rdata, inst_rvalid,
        output data_req_ready, data_rdata, data_rvalid,
        output mem_addr, mem_wen, mem_wdata, mem_wstrb, mem_ren, mem_rready
    );

    modport master (
        output inst_addr, inst_req_valid, inst_rready,
        output data_addr, data_wen, data_wdata, data_wstrb, data_ren, data_rready,
        output mem_req_ready, mem_rdata, mem_rvalid,
        input  inst_req_ready, inst_rdata, inst_rvalid,
        input  data_req_ready, data_rdata, data_rvalid,
        input  mem_addr, mem_wen, mem_wdata, mem_wstrb, mem_ren, mem_rready
    );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// Shares one memory port between the CPU fetch and data channels; data has priority,
// with a starvation guard that forces a fetch grant after STARVE_LIMIT data grants.
//   state | meaning
//   IDLE  | no grant; arbitrate pending requests
//   REQ   | granted request presented to memory
//   RESP  | waiting for read data for the owner
module cpu_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    cpu_mem_arbiter_if.slave  bus
);
    localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       r_owner;
    logic [3:0] r_starve_cnt;

    logic       w_data_pend;
    logic       w_starve_hit;
    logic       w_grant_inst;
    logic       w_grant_data;
    logic [3:0] w_starve_next;
    logic       w_own_valid;
    logic       w_own_write;
    logic       w_own_rready;

    assign w_data_pend   = bus.data_wen | bus.data_ren;
    assign w_starve_hit  = (STARVE_LIMIT != 0) && (r_starve_cnt == LP_LIMIT);
    assign w_grant_inst  = bus.inst_req_valid & (~w_data_pend | w_starve_hit);
    assign w_grant_data  = w_data_pend & ~w_grant_inst;
    assign w_own_valid   = r_owner ? w_data_pend : bus.inst_req_valid;
    assign w_own_write   = r_owner & bus.data_wen;
    assign w_own_rready  = r_owner ? bus.data_rready : bus.inst_rready;

    // Count only data grants that actually made a fetch wait.
    always_comb begin
        w_starve_next = 4'd0;
        if (w_grant_data && bus.inst_req_valid)
            w_starve_next = (r_starve_cnt == 4'd15) ? 4'd15 : r_starve_cnt + 4'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_owner      <= 1'b0;
            r_starve_cnt <= 4'd0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && (w_grant_inst || w_grant_data)) begin
                r_owner      <= w_grant_data;
                r_starve_cnt <= w_starve_next;
            end
        end
    end

    always_comb begin
        w_next             = r_state;
        bus.inst_req_ready = 1'b0;
        bus.inst_rdata     = '0;
        bus.inst_rvalid    = 1'b0;
        bus.data_req_ready = 1'b0;
        bus.data_rdata     = '0;
        bus.data_rvalid    = 1'b0;
        bus.mem_addr       = '0;
        bus.mem_wen        = 1'b0;
        bus.mem_wdata      = '0;
        bus.mem_wstrb      = '0;
        bus.mem_ren        = 1'b0;
        bus.mem_rready     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_inst || w_grant_data)
                    w_next = REQ;
            end
            REQ: begin
                if (r_owner) begin
                    bus.mem_addr       = w_data_pend ? bus.data_addr : '0;
                    bus.mem_wen        = bus.data_wen;
                    bus.mem_ren        = bus.data_ren & ~bus.data_wen;
                    bus.mem_wdata      = bus.data_wen ? bus.data_wdata : '0;
                    bus.mem_wstrb      = bus.data_wen ? bus.data_wstrb : '0;
                    bus.data_req_ready = bus.mem_req_ready;
                end else begin
                    bus.mem_addr       = bus.inst_req_valid ? bus.inst_addr : '0;
                    bus.mem_ren        = bus.inst_req_valid;
                    bus.inst_req_ready = bus.mem_req_ready;
                end
                // A dropped valid abandons the grant without a memory transaction.
                if (!w_own_valid)
                    w_next = IDLE;
                else if (bus.mem_req_ready)
                    w_next = w_own_write ? IDLE : RESP;
            end
            RESP: begin
                bus.mem_rready = w_own_rready;
                if (r_owner) begin
                    bus.data_rdata  = bus.mem_rdata;
                    bus.data_rvalid = bus.mem_rvalid;
                end else begin
                    bus.inst_rdata  = bus.mem_rdata;
                    bus.inst_rvalid = bus.mem_rvalid;
                end
                if (bus.mem_rvalid && w_own_rready)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end
endmodule

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
- Shares one memory port between the custom CPU's instruction-fetch channel and its data channel, for unified-memory SoC builds.
- Grants one requester at a time and holds the grant until that transaction finishes.
- For a read, the transaction finishes when its response is delivered; for a write, when the request is accepted.
- Data requests have priority over fetches. A starvation guard forces an instruction grant after a bounded run of data grants.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; write strobe is DATA_W/8 bits.
- STARVE_LIMIT, 4, consecutive data grants allowed while a fetch waits (0 = guard disabled, max 15).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- inst_addr  in  ADDR_W  fetch address
- inst_req_valid  in  1  fetch request valid
- inst_req_ready  out  1  fetch request accepted
- inst_rdata  out  DATA_W  fetched word
- inst_rvalid  out  1  fetched word valid
- inst_rready  in  1  CPU accepts fetched word
- data_addr  in  ADDR_W  load/store address
- data_wen  in  1  store request
- data_wdata  in  DATA_W  store data
- data_wstrb  in  DATA_W/8  store byte strobe
- data_ren  in  1  load request
- data_req_ready  out  1  load/store request accepted
- data_rdata  out  DATA_W  load data
- data_rvalid  out  1  load data valid
- data_rready  in  1  CPU accepts load data
- mem_addr  out  ADDR_W  memory address
- mem_wen  out  1  memory write
- mem_wdata  out  DATA_W  memory write data
- mem_wstrb  out  DATA_W/8  memory strobe
- mem_ren  out  1  memory read
- mem_req_ready  in  1  memory accepts request
- mem_rdata  in  DATA_W  memory read data
- mem_rvalid  in  1  memory read data valid
- mem_rready  out  1  arbiter accepts read data

Behaviour:
- State machine states:
  - IDLE: no grant.
  - REQ: granted request presented to memory.
  - RESP: waiting for read data.
- Registers: owner (0 = inst, 1 = data) and starve_cnt (4 bits).
- Reset (rst low, asynchronous):
  - State goes to IDLE, owner = 0, starve_cnt = 0.
  - All outputs are 0.
  - An in-flight memory transaction is abandoned; memory must be reset together with the arbiter.
- Data request pending = data_wen | data_ren. If both are high, the write wins and mem_ren is forced to 0.
- IDLE:
  - All ready/valid outputs are 0; mem_* outputs are 0.
  - Arbitration on the registered edge:
    - Only one side pending: grant it.
    - Both pending: grant inst if STARVE_LIMIT != 0 and starve_cnt == STARVE_LIMIT; otherwise grant data.
  - Go to REQ. Grant latency is one cycle; the request is never forwarded in the same cycle it is first seen.
- starve_cnt update:
  - Increments on a data grant while inst_req_valid = 1.
  - Clears on an inst grant, or on any grant while inst_req_valid = 0.
  - Saturates at 15.
- REQ:
  - mem_addr, mem_wen, mem_wdata, mem_wstrb and mem_ren are driven from the owner's inputs, gated by the owner's valid; the non-owner fields are ignored.
  - The owner's req_ready equals mem_req_ready; the other side's req_ready is 0.
  - On mem handshake:
    - Write: go to IDLE.
    - Read: go to RESP.
  - If the owner drops valid before the handshake (protocol violation), go to IDLE with no transaction.
- RESP:
  - The owner's rdata equals mem_rdata and its rvalid equals mem_rvalid; mem_rready equals the owner's rready.
  - The non-owner rvalid is 0.
  - On mem_rvalid & mem_rready, go to IDLE.
- Outside RESP, mem_rready = 0 and stray mem_rvalid is ignored.
- The fetch channel issues reads only; inst writes are impossible.
- Throughput: one transaction per 2 cycles minimum for writes (IDLE, REQ) and 3 cycles for reads with zero-latency memory.
- Requests arriving while the arbiter is busy wait; valid must stay high and inputs stable until accepted.

Test Plan:
- Inst-only read: inst_req_valid = 1, inst_addr = 0x100, mem_req_ready = 1, memory returns 0x00000013 one cycle later.
  - Required: mem_ren = 1 in cycle 1; inst_rdata = 0x13 with inst_rvalid; back in IDLE after the response handshake.
- Simultaneous requests, STARVE_LIMIT = 4, store to 0x200 with wstrb = 0xF:
  - Required: data is granted first, mem_wen = 1 with mem_addr = 0x200; returns to IDLE on accept without entering RESP; fetch granted next.
- Starvation: data and inst requests both held continuously, STARVE_LIMIT = 2.
  - Required: grant order data, data, inst, data, data, inst.
- Backpressure: mem_req_ready = 0 for 5 cycles, then the load response is held with data_rready = 0 for 3 cycles.
  - Required: request signals stable throughout; data_req_ready rises only with mem_req_ready; mem_rready = 0 until data_rready rises.
  - inst_rvalid stays 0 throughout.
- Reset in RESP: assert rst low mid-read, asynchronously.
  - Required: all outputs 0 in the same cycle; after release, state IDLE and starve_cnt = 0.
- data_wen = data_ren = 1:
  - Required: mem_wen = 1, mem_ren = 0; completes as a write with no RESP state.
